// File: rtl/img_mat_pattern_src.sv
// Frame-timed test-pattern source for the mat stream: ramp, checker or solid pixels with
// programmable horizontal/vertical blanking. All outputs are registered; cke freezes everything.
module img_mat_pattern_src #(
    parameter int unsigned TAPS       = 1,
    parameter int unsigned ROWS_BITS  = 10,
    parameter int unsigned COLS_BITS  = 11,
    parameter int unsigned DE_BITS    = 1,
    parameter int unsigned USER_BITS  = 1,
    parameter int unsigned CH_BITS    = 10,
    parameter int unsigned BLANK_BITS = 16
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      cke,
    input  logic                      enable,
    input  logic [ROWS_BITS-1:0]      param_rows,
    input  logic [COLS_BITS-1:0]      param_cols,
    input  logic [BLANK_BITS-1:0]     param_h_blank,
    input  logic [BLANK_BITS-1:0]     param_v_blank,
    input  logic [1:0]                param_pattern,
    input  logic [CH_BITS-1:0]        param_solid,
    output logic                      busy,
    output logic [ROWS_BITS-1:0]      m_mat_rows,
    output logic [COLS_BITS-1:0]      m_mat_cols,
    output logic                      m_mat_row_first,
    output logic                      m_mat_row_last,
    output logic                      m_mat_col_first,
    output logic                      m_mat_col_last,
    output logic [DE_BITS-1:0]        m_mat_de,
    output logic [USER_BITS-1:0]      m_mat_user,
    output logic [TAPS*CH_BITS-1:0]   m_mat_data,
    output logic                      m_mat_valid
);

    typedef enum logic [1:0] {StIdle, StActive, StHblank, StVblank} state_e;

    state_e                  state_q, state_d;
    logic [COLS_BITS-1:0]    x_q, x_d, cols_q, cols_d;
    logic [ROWS_BITS-1:0]    y_q, y_d, rows_q, rows_d;
    logic [BLANK_BITS-1:0]   cnt_q, cnt_d, hb_q, hb_d, vb_q, vb_d;
    logic [1:0]              pat_q, pat_d;
    logic [CH_BITS-1:0]      solid_q, solid_d;

    logic                    busy_d, valid_d, rf_d, rl_d, cf_d, cl_d;
    logic [USER_BITS-1:0]    user_d;
    logic [TAPS*CH_BITS-1:0] data_d;
    logic                    start_ok, start, eof;
    logic [31:0]             px, y32;
    logic [CH_BITS-1:0]      sum, tap;

    assign start_ok = enable && (param_rows != '0) && (param_cols >= COLS_BITS'(TAPS));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        hb_d    = hb_q;
        vb_d    = vb_q;
        pat_d   = pat_q;
        solid_d = solid_q;
        start   = 1'b0;
        eof     = 1'b0;
        case (state_q)
            StIdle: start = start_ok;
            StActive: begin
                if (x_q == cols_q - COLS_BITS'(TAPS)) begin
                    if (y_q != rows_q - ROWS_BITS'(1)) begin
                        if (hb_q != '0) begin
                            state_d = StHblank;
                            cnt_d   = '0;
                        end else begin
                            x_d = '0;
                            y_d = y_q + ROWS_BITS'(1);
                        end
                    end else if (vb_q != '0) begin
                        state_d = StVblank;
                        cnt_d   = '0;
                    end else begin
                        eof = 1'b1;
                    end
                end else begin
                    x_d = x_q + COLS_BITS'(TAPS);
                end
            end
            StHblank: begin
                if (cnt_q == hb_q - BLANK_BITS'(1)) begin
                    state_d = StActive;
                    x_d     = '0;
                    y_d     = y_q + ROWS_BITS'(1);
                end else begin
                    cnt_d = cnt_q + BLANK_BITS'(1);
                end
            end
            StVblank: begin
                if (cnt_q == vb_q - BLANK_BITS'(1)) eof = 1'b1;
                else cnt_d = cnt_q + BLANK_BITS'(1);
            end
            default: state_d = StIdle;
        endcase
        if (eof) begin
            if (start_ok) start = 1'b1;
            else state_d = StIdle;
        end
        // Parameters are captured only here, so they stay fixed for the whole frame.
        if (start) begin
            state_d = StActive;
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            rows_d  = param_rows;
            cols_d  = param_cols;
            hb_d    = param_h_blank;
            vb_d    = param_v_blank;
            pat_d   = param_pattern;
            solid_d = param_solid;
        end
    end

    // Output registers are loaded from next-state values so the beat tracks the state register.
    always_comb begin
        busy_d  = (state_d != StIdle);
        valid_d = (state_d == StActive);
        rf_d    = valid_d && (y_d == '0);
        rl_d    = valid_d && (y_d == rows_d - ROWS_BITS'(1));
        cf_d    = valid_d && (x_d == '0);
        cl_d    = valid_d && (x_d == cols_d - COLS_BITS'(TAPS));
        user_d    = '0;
        user_d[0] = rf_d && cf_d;
        data_d  = '0;
        px      = '0;
        sum     = '0;
        tap     = '0;
        y32     = 32'(y_d);
        for (int t = 0; t < TAPS; t++) begin
            px  = 32'(x_d) + 32'(t);
            sum = CH_BITS'(px + y32);
            case (pat_d)
                2'd0:    tap = sum;
                2'd1:    tap = (px[3] ^ y32[3]) ? '1 : '0;
                2'd2:    tap = solid_d;
                default: tap = '0;
            endcase
            data_d[t*CH_BITS +: CH_BITS] = valid_d ? tap : '0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= StIdle;
            x_q             <= '0;
            y_q             <= '0;
            cnt_q           <= '0;
            rows_q          <= '0;
            cols_q          <= '0;
            hb_q            <= '0;
            vb_q            <= '0;
            pat_q           <= '0;
            solid_q         <= '0;
            busy            <= 1'b0;
            m_mat_row_first <= 1'b0;
            m_mat_row_last  <= 1'b0;
            m_mat_col_first <= 1'b0;
            m_mat_col_last  <= 1'b0;
            m_mat_de        <= '0;
            m_mat_user      <= '0;
            m_mat_data      <= '0;
            m_mat_valid     <= 1'b0;
        end else if (cke) begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            cnt_q           <= cnt_d;
            rows_q          <= rows_d;
            cols_q          <= cols_d;
            hb_q            <= hb_d;
            vb_q            <= vb_d;
            pat_q           <= pat_d;
            solid_q         <= solid_d;
            busy            <= busy_d;
            m_mat_row_first <= rf_d;
            m_mat_row_last  <= rl_d;
            m_mat_col_first <= cf_d;
            m_mat_col_last  <= cl_d;
            m_mat_de        <= {DE_BITS{valid_d}};
            m_mat_user      <= user_d;
            m_mat_data      <= data_d;
            m_mat_valid     <= valid_d;
        end
    end

    assign m_mat_rows = rows_q;
    assign m_mat_cols = cols_q;

endmodule

// File: doc/img_mat_pattern_src.md
Name: img_mat_pattern_src

Overview:
- Frame-timed source for the mat stream protocol; the transmitting end consumed by filter cores such as the 3x3 Gaussian stage.
- Generates rows/cols, first/last flags, de, user and per-tap pixel data with programmable horizontal and vertical blanking.
- Used as a test-pattern generator and a bring-up source ahead of the optical-flow pipeline.

Parameters:
TAPS, 1, pixels per beat; frame width must be a multiple of TAPS
ROWS_BITS, 10, width of row count
COLS_BITS, 11, width of column count (pixels)
DE_BITS, 1, width of de
USER_BITS, 1, width of user; bit0 = frame start
CH_BITS, 10, bits per pixel per tap
BLANK_BITS, 16, width of blanking counters

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cke  in  1  clock enable; 0 freezes all state and outputs
enable  in  1  run request, sampled at frame boundaries
param_rows  in  ROWS_BITS  frame height
param_cols  in  COLS_BITS  frame width in pixels
param_h_blank  in  BLANK_BITS  idle beats after each row
param_v_blank  in  BLANK_BITS  idle beats after each frame
param_pattern  in  2  0=ramp, 1=checker, 2=solid, 3=reserved (outputs 0)
param_solid  in  CH_BITS  solid colour value
busy  out  1  frame in progress
m_mat_rows  out  ROWS_BITS  latched frame height
m_mat_cols  out  COLS_BITS  latched frame width
m_mat_row_first  out  1  beat is in row 0
m_mat_row_last  out  1  beat is in last row
m_mat_col_first  out  1  first beat of row
m_mat_col_last  out  1  last beat of row
m_mat_de  out  DE_BITS  active pixel, all bits = valid
m_mat_user  out  USER_BITS  bit0 = row_first & col_first, other bits 0
m_mat_data  out  TAPS*CH_BITS  pixel data, tap 0 in LSBs
m_mat_valid  out  1  beat valid

Behaviour:
- Async reset (aresetn=0): state IDLE, all outputs 0, all counters 0. Reset mid-frame aborts the frame; no partial flags remain.
- All outputs are registered. Nothing advances when cke=0.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE -> ACTIVE: enable=1, param_rows!=0 and param_cols>=TAPS.
  - On this transition, latch rows, cols, blanks, pattern and solid. Parameters are fixed for the whole frame.
  - First valid beat appears on the next cke cycle.
  - If enable=1 with an illegal size, remain IDLE.
- ACTIVE: one beat per cke cycle; x advances by TAPS.
  - col_first when x==0.
  - col_last when x==cols-TAPS.
  - row_first when y==0.
  - row_last when y==rows-1.
- After col_last:
  - Not the last row: go to HBLANK if h_blank!=0, else continue ACTIVE on the next row (back-to-back).
  - Last row: go to VBLANK if v_blank!=0, else end-of-frame.
- HBLANK: valid=0, de=0, flags=0; count h_blank cycles, then ACTIVE on row y+1, x=0.
- VBLANK: valid=0; count v_blank cycles, then end-of-frame.
- End-of-frame decision: if enable=1 and the live parameters are legal, relatch and start the next frame (ACTIVE) on the next cycle; otherwise go to IDLE. Deasserting enable mid-frame lets the frame complete.
- busy=1 in ACTIVE, HBLANK and VBLANK.
- Data for tap t, with column px = x+t:
  - ramp: (px + y) truncated to CH_BITS.
  - checker: all-ones if ((px>>3) ^ (y>>3)) & 1, else 0.
  - solid: param_solid.
- Flags, de and user are forced to 0 whenever valid=0. Data is don't-care when valid=0; the implementation drives 0.
- cols not a multiple of TAPS: x compares use cols-TAPS, so the trailing remainder is dropped. This case is documented as unsupported.
- m_mat_rows and m_mat_cols hold the latched values during a frame and keep their last value in IDLE (0 after reset).

Test Plan:
- TAPS=1, rows=2, cols=4, h_blank=2, v_blank=3, ramp, enable held:
  - valid pattern is 1111 00 1111 000 then repeats.
  - Row 0 data is 0,1,2,3; row 1 data is 1,2,3,4.
  - user=1 only on the first beat.
- TAPS=2, rows=1, cols=2, h_blank=0, v_blank=0:
  - Every cycle valid=1, with row_first=row_last=col_first=col_last=1.
  - Data {1,0} on every beat.
- Toggle cke 1/0 on alternate cycles with the first scenario's settings: identical beat sequence, each beat held two cycles, valid unchanged while cke=0.
- Drop enable at row 1 of a 4-row frame: the frame completes all 4 rows, then busy=0 and valid stays 0. Reasserting enable starts a new frame with user=1.
- Assert aresetn=0 mid-row:
  - All outputs are 0 immediately (async).
  - After release with enable=1, a fresh frame starts at row_first=col_first=1.
- Illegal parameters: rows=0 (and separately cols=0 with TAPS=2) with enable=1 -> busy stays 0 and valid stays 0. Checker with CH_BITS=10 at px=8, y=0 -> 0x3FF; at px=8, y=8 -> 0.
